srl_iter: RTL and testbench



---
 rtl/srl_iter.sv | 89 ++++++++
 tb/tb_srl_iter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srl_iter.sv
// rtl/srl_iter.sv - iterative multi-cycle logical/arithmetic right shifter
// Shifts at most STEP places per cycle; result held until the consumer accepts it.
module srl_iter #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in,
  input  logic [4:0]  sa,
  input  logic        arith,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy
);

  localparam logic [4:0] STEP_K = 5'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  rem_q, rem_d;
  logic        fill_q, fill_d;

  logic [4:0]  step_k;
  logic [31:0] fill_mask;
  logic [31:0] shifted;

  // Final step may be shorter than STEP; fill mask covers exactly the vacated bits.
  always_comb begin
    step_k    = (rem_q < STEP_K) ? rem_q : STEP_K;
    fill_mask = fill_q ? ~(32'hFFFF_FFFF >> step_k) : 32'h0;
    shifted   = (data_q >> step_k) | fill_mask;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      data_q  <= 32'h0;
      rem_q   <= 5'd0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in;
          rem_d   = sa;
          fill_d  = arith & in[31];
          state_d = (sa == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - step_k;
        if (rem_q == step_k) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode straight from state so an async reset drops them at once.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = data_q;

endmodule

// File: tb/tb_srl_iter.sv
// tb/tb_srl_iter.sv - randomized and directed bench for srl_iter
// Three instances (STEP=1, 4, 16) share clock and reset; index 1 is the STEP=4 unit.
module tb_srl_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid_a[3];
  logic        in_ready_a[3];
  logic [31:0] in_a[3];
  logic [4:0]  sa_a[3];
  logic        arith_a[3];
  logic        out_valid_a[3];
  logic        out_ready_a[3];
  logic [31:0] out_a[3];
  logic        busy_a[3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    srl_iter #(.STEP(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in        (in_a[g]),
      .sa        (sa_a[g]),
      .arith     (arith_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out       (out_a[g]),
      .busy      (busy_a[g])
    );
  end

  function automatic int step_of(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 4 : 16);
  endfunction

  function automatic logic [31:0] ref_shift(input logic [31:0] din, input logic [4:0] dsa,
                                            input logic darith);
    logic [31:0] r;
    if (darith) r = $signed(din) >>> dsa;
    else        r = din >> dsa;
    return r;
  endfunction

  function automatic int ref_lat(input logic [4:0] dsa, input int step);
    int s;
    s = int'(dsa);
    return (s == 0) ? 1 : 1 + (s + step - 1) / step;
  endfunction

  // Latency counts the accept edge as cycle 1, up to the first cycle showing out_valid.
  task automatic run_op(input int idx, input logic [31:0] din, input logic [4:0] dsa,
                        input logic darith, input bit junk,
                        output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready_a[idx] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid_a[idx] = 1'b1;
    in_a[idx]       = din;
    sa_a[idx]       = dsa;
    arith_a[idx]    = darith;
    @(posedge clk); #1;
    in_valid_a[idx] = 1'b0;
    lat = 1;
    while (!out_valid_a[idx] && lat < 64) begin
      if (junk) begin
        in_valid_a[idx]  = 1'($urandom);
        in_a[idx]        = $urandom;
        sa_a[idx]        = 5'($urandom);
        arith_a[idx]     = 1'($urandom);
        out_ready_a[idx] = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid_a[idx]  = 1'b0;
    out_ready_a[idx] = 1'b0;
    res = out_a[idx];
  endtask

  task automatic release_out(input int idx);
    out_ready_a[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[idx] = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_ready_a[i] !== 1'b1 || out_valid_a[i] !== 1'b0 || out_a[i] !== 32'h0 ||
          busy_a[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out=%h busy=%b, want 1 0 0 0",
                 i, in_ready_a[i], out_valid_a[i], out_a[i], busy_a[i]);
      end
    end
  endtask

  task automatic test_logical;
    logic [31:0] res;
    int lat;
    run_op(1, 32'h8000_0000, 5'd4, 1'b0, 1'b0, res, lat);
    tests++;
    if (res !== 32'h0800_0000 || lat !== 2) begin
      fails++;
      $display("FAIL logical: out=%h lat=%0d, want 08000000 lat 2", res, lat);
    end
    release_out(1);
  endtask

  task automatic test_arith;
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(i, 32'h8000_0001, 5'd31, 1'b1, 1'b0, res, lat);
      tests++;
      if (res !== 32'hFFFF_FFFF || lat !== ref_lat(5'd31, step_of(i))) begin
        fails++;
        $display("FAIL arith_sa31[%0d]: out=%h lat=%0d, want ffffffff lat %0d",
                 i, res, lat, ref_lat(5'd31, step_of(i)));
      end
      release_out(i);
    end
    run_op(1, 32'h8000_0001, 5'd31, 1'b0, 1'b0, res, lat);
    tests++;
    if (res !== 32'h0000_0001 || lat !== 9) begin
      fails++;
      $display("FAIL logical_sa31: out=%h lat=%0d, want 00000001 lat 9", res, lat);
    end
    release_out(1);
  endtask

  task automatic test_zero_and_positive;
    logic [31:0] res;
    int lat;
    run_op(1, 32'h1234_5678, 5'd0, 1'b1, 1'b0, res, lat);
    tests++;
    if (res !== 32'h1234_5678 || lat !== 1) begin
      fails++;
      $display("FAIL zero_shift: out=%h lat=%0d, want 12345678 lat 1", res, lat);
    end
    release_out(1);
    run_op(1, 32'h7000_0000, 5'd3, 1'b1, 1'b0, res, lat);
    tests++;
    if (res !== 32'h0E00_0000 || lat !== 2) begin
      fails++;
      $display("FAIL pos_arith: out=%h lat=%0d, want 0e000000 lat 2", res, lat);
    end
    release_out(1);
  endtask

  task automatic test_backpressure;
    logic [31:0] res, res2;
    int lat;
    run_op(1, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, res, lat);
    tests++;
    if (res !== 32'hFFDE_ADBE) begin
      fails++;
      $display("FAIL bp_first: out=%h, want ffdeadbe", res);
    end
    in_valid_a[1] = 1'b1;
    in_a[1]       = 32'h00F0_0000;
    sa_a[1]       = 5'd20;
    arith_a[1]    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests++;
      if (out_a[1] !== 32'hFFDE_ADBE || out_valid_a[1] !== 1'b1 || in_ready_a[1] !== 1'b0 ||
          busy_a[1] !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold[%0d]: out=%h out_valid=%b in_ready=%b busy=%b, want ffdeadbe 1 0 1",
                 c, out_a[1], out_valid_a[1], in_ready_a[1], busy_a[1]);
      end
    end
    out_ready_a[1] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[1] = 1'b0;
    tests++;
    if (in_ready_a[1] !== 1'b1 || out_valid_a[1] !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready_a[1], out_valid_a[1]);
    end
    @(posedge clk); #1;
    in_valid_a[1] = 1'b0;
    tests++;
    if (busy_a[1] !== 1'b1) begin
      fails++;
      $display("FAIL bp_second_accept: busy=%b, want 1", busy_a[1]);
    end
    lat = 1;
    while (!out_valid_a[1] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res2 = out_a[1];
    tests++;
    if (res2 !== 32'h0000_000F || lat !== 6) begin
      fails++;
      $display("FAIL bp_second: out=%h lat=%0d, want 0000000f lat 6", res2, lat);
    end
    release_out(1);
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int lat;
    in_valid_a[1] = 1'b1;
    in_a[1]       = 32'hA5A5_A5A5;
    sa_a[1]       = 5'd20;
    arith_a[1]    = 1'b1;
    @(posedge clk); #1;
    in_valid_a[1] = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    tests++;
    if (out_valid_a[1] !== 1'b0 || in_ready_a[1] !== 1'b1 || out_a[1] !== 32'h0 ||
        busy_a[1] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b out=%h busy=%b, want 0 1 0 0",
               out_valid_a[1], in_ready_a[1], out_a[1], busy_a[1]);
    end
    #3;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op(1, 32'hFFFF_0000, 5'd16, 1'b0, 1'b0, res, lat);
    tests++;
    if (res !== 32'h0000_FFFF || lat !== 5) begin
      fails++;
      $display("FAIL after_reset: out=%h lat=%0d, want 0000ffff lat 5", res, lat);
    end
    release_out(1);
  endtask

  task automatic test_random;
    logic [31:0] din, res, want;
    logic [4:0]  dsa;
    logic        dar;
    int          lat, stall, n;
    for (int i = 0; i < 3; i++) begin
      n = (i == 0) ? 334 : 333;
      for (int t = 0; t < n; t++) begin
        din = $urandom;
        dsa = 5'($urandom);
        dar = 1'($urandom);
        want = ref_shift(din, dsa, dar);
        run_op(i, din, dsa, dar, 1'b1, res, lat);
        tests++;
        if (res !== want || lat !== ref_lat(dsa, step_of(i))) begin
          fails++;
          $display("FAIL rand[%0d] in=%h sa=%0d arith=%b: out=%h lat=%0d, want %h lat %0d",
                   i, din, dsa, dar, res, lat, want, ref_lat(dsa, step_of(i)));
        end
        stall = $urandom_range(0, 3);
        for (int c = 0; c < stall; c++) begin
          in_valid_a[i] = 1'($urandom);
          @(posedge clk); #1;
          tests++;
          if (out_a[i] !== want || out_valid_a[i] !== 1'b1) begin
            fails++;
            $display("FAIL rand_stall[%0d]: out=%h out_valid=%b, want %h 1",
                     i, out_a[i], out_valid_a[i], want);
          end
        end
        in_valid_a[i] = 1'b0;
        release_out(i);
        tests++;
        if (in_ready_a[i] !== 1'b1) begin
          fails++;
          $display("FAIL rand_idle[%0d]: in_ready=%b, want 1", i, in_ready_a[i]);
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      in_a[i]        = 32'h0;
      sa_a[i]        = 5'd0;
      arith_a[i]     = 1'b0;
      out_ready_a[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #4;
    resetn = 1'b1;
    @(posedge clk); #1;
    test_logical();
    test_arith();
    test_zero_and_positive();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
